fetch_unit: RTL and testbench

- Instruction-fetch stage of the multi-cycle RV32I core; sits directly upstream of the instruction decoder.
- Owns the program counter and issues word reads to instruction memory over a ready-handshake.
- Latches the returned instruction, then pulses the decoder's decode strobe.
- Waits for the rest of the core to retire the instruction, then advances the PC to PC+4 or to a redirect target.

---
 rtl/fetch_unit_pkg.sv | 37 +++
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the RV32I multi-cycle core front end.
// Fetch FSM states, fault codes, reset PC and base opcodes.
package fetch_unit_pkg;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_WAIT_ID = 3'd2,
    S_EXEC    = 3'd3,
    S_HALT    = 3'd4
  } fetch_state_e;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  localparam logic [31:0] RESET_PC_DEF = 32'h0100_0000;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  function automatic logic word_aligned(
    input logic [31:0] addr
  );
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads imem,
// strobes the decoder and advances on retire.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
  parameter int          IMEM_TIMEOUT = 16,
  parameter int          CNT_W        = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instruction,
  output logic        decode,
  input  logic        id_comp,
  input  logic        halt,
  input  logic        retire,
  input  logic        pc_write,
  input  logic [31:0] pc_next,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic [1:0]  fault
);

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(IMEM_TIMEOUT - 1);

  fetch_state_e     state;
  logic [CNT_W-1:0] cnt;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // Fetch/decode/execute sequencer with registered outputs.
  // The first FETCH cycle only issues the request, so a
  // ready strobe there is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instruction <= '0;
      decode      <= 1'b0;
      imem_req    <= 1'b0;
      halted      <= 1'b0;
      fault       <= FAULT_NONE;
      cnt         <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (!imem_req) begin
            if (!word_aligned(pc)) begin
              fault  <= FAULT_MISALIGN;
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              imem_req <= 1'b1;
              cnt      <= '0;
            end
          end else if (imem_ready) begin
            instruction <= imem_rdata;
            imem_req    <= 1'b0;
            cnt         <= '0;
            decode      <= 1'b1;
            state       <= S_DECODE;
          end else if (cnt == TO_LAST) begin
            fault    <= FAULT_TIMEOUT;
            halted   <= 1'b1;
            imem_req <= 1'b0;
            cnt      <= '0;
            state    <= S_HALT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          decode <= 1'b0;
          state  <= S_WAIT_ID;
        end
        S_WAIT_ID: begin
          if (id_comp) begin
            if (halt) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (retire) begin
            pc    <= pc_write ? pc_next : pc_plus4;
            state <= S_FETCH;
          end
        end
        S_HALT: begin
          imem_req <= 1'b0;
          decode   <= 1'b0;
          halted   <= 1'b1;
        end
        default: begin
          imem_req <= 1'b0;
          decode   <= 1'b0;
          halted   <= 1'b1;
          state    <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch, redirect, halt,
// misalign, timeout, wrap and async reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instruction;
  logic        decode;
  logic        id_comp;
  logic        halt;
  logic        retire;
  logic        pc_write;
  logic [31:0] pc_next;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic [1:0]  fault;

  int passed;
  int total;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .instruction(instruction),
    .decode     (decode),
    .id_comp    (id_comp),
    .halt       (halt),
    .retire     (retire),
    .pc_write   (pc_write),
    .pc_next    (pc_next),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .halted     (halted),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    imem_rdata = '0;
    imem_ready = 1'b0;
    id_comp    = 1'b0;
    halt       = 1'b0;
    retire     = 1'b0;
    pc_write   = 1'b0;
    pc_next    = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Starts and ends at the issue cycle of FETCH.
  task automatic do_instr(
    input logic [31:0] word,
    input logic        pw,
    input logic [31:0] tgt
  );
    tick();
    imem_ready = 1'b1;
    imem_rdata = word;
    tick();
    imem_ready = 1'b0;
    tick();
    id_comp = 1'b1;
    tick();
    id_comp  = 1'b0;
    retire   = 1'b1;
    pc_write = pw;
    pc_next  = tgt;
    tick();
    retire   = 1'b0;
    pc_write = 1'b0;
  endtask

  initial begin
    int reqs;
    passed = 0;
    total  = 0;

    do_reset();
    chk("rst_pc", pc, 32'h0100_0000);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);

    tick();
    chk("f1_req", 32'(imem_req), 32'd1);
    chk("f1_addr", imem_addr, 32'h0100_0000);
    imem_ready = 1'b1;
    imem_rdata = 32'h0050_0093;
    tick();
    imem_ready = 1'b0;
    chk("f1_instr", instruction, 32'h0050_0093);
    chk("f1_dec_hi", 32'(decode), 32'd1);
    chk("f1_req_lo", 32'(imem_req), 32'd0);
    tick();
    chk("f1_dec_lo", 32'(decode), 32'd0);
    id_comp = 1'b1;
    tick();
    id_comp = 1'b0;
    retire  = 1'b1;
    tick();
    retire = 1'b0;
    chk("f1_pc4", pc, 32'h0100_0004);

    do_instr(32'h0400_006f, 1'b1, 32'h0100_0040);
    chk("rd_pc", pc, 32'h0100_0040);
    chk("rd_pc4", pc_plus4, 32'h0100_0044);
    tick();
    chk("rd_addr", imem_addr, 32'h0100_0040);

    imem_ready = 1'b1;
    imem_rdata = 32'h0000_0073;
    tick();
    imem_ready = 1'b0;
    tick();
    id_comp = 1'b1;
    halt    = 1'b1;
    tick();
    id_comp  = 1'b0;
    halt     = 1'b0;
    retire   = 1'b1;
    pc_write = 1'b1;
    pc_next  = 32'h0000_0200;
    chk("hl_halted", 32'(halted), 32'd1);
    chk("hl_fault", 32'(fault), 32'd0);
    reqs = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (imem_req) reqs++;
    end
    retire   = 1'b0;
    pc_write = 1'b0;
    chk("hl_noreq", 32'(reqs), 32'd0);
    chk("hl_pc", pc, 32'h0100_0040);

    do_reset();
    do_instr(32'h0000_0013, 1'b1, 32'h0100_0042);
    chk("ma_pc", pc, 32'h0100_0042);
    tick();
    chk("ma_fault", 32'(fault), 32'd1);
    chk("ma_halted", 32'(halted), 32'd1);
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      if (imem_req) reqs++;
      tick();
    end
    chk("ma_noreq", 32'(reqs), 32'd0);

    do_reset();
    tick();
    reqs = 0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req) begin
        reqs++;
        tick();
      end
    end
    chk("to_cycles", 32'(reqs), 32'd16);
    chk("to_fault", 32'(fault), 32'd2);
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_req", 32'(imem_req), 32'd0);

    do_reset();
    do_instr(32'h0000_0013, 1'b1, 32'hFFFF_FFFC);
    chk("wr_pc4", pc_plus4, 32'h0000_0000);
    do_instr(32'h0000_0013, 1'b0, 32'h0);
    chk("wr_pc", pc, 32'h0000_0000);
    chk("wr_fault", 32'(fault), 32'd0);

    do_reset();
    do_instr(32'h1234_5013, 1'b0, 32'h0);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("ig_req", 32'(imem_req), 32'd1);
    chk("ig_dec", 32'(decode), 32'd0);
    chk("ig_instr", instruction, 32'h1234_5013);
    imem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req", 32'(imem_req), 32'd0);
    chk("ar_pc", pc, 32'h0100_0000);
    chk("ar_instr", instruction, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_resume_req", 32'(imem_req), 32'd1);
    chk("ar_resume_addr", imem_addr, 32'h0100_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
